// File: rtl/md_defs.sv
// Shared multiply/divide definitions: md_op encodings, default latencies and
// the controller state type, imported by the decoder, hazard unit and md unit.
package md_defs;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  // Wide enough for any sensible latency parameter.
  localparam int unsigned MD_CNT_W = 16;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Purely combinational multiply/divide arithmetic: produces the HI/LO pair for
// mult/multu/div/divu and flags a zero divisor on the divide ops.
module md_calc
  import md_defs::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div0_o
);

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

  logic signed [63:0] sa, sb, prod_s;
  logic        [63:0] prod_u;
  logic               div_signed;
  logic        [31:0] mag_a, mag_b, safe_b;
  logic        [31:0] q_mag, r_mag, quot, rem;

  assign sa     = {{32{a_i[31]}}, a_i};
  assign sb     = {{32{b_i[31]}}, b_i};
  assign prod_s = sa * sb;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide works on magnitudes so 0x80000000 / -1 cannot overflow;
  // quotient truncates toward zero, remainder follows the dividend's sign.
  assign div_signed = (op_i == MD_DIV);
  assign mag_a      = div_signed ? abs32(a_i) : a_i;
  assign mag_b      = div_signed ? abs32(b_i) : b_i;
  assign safe_b     = (b_i == 32'd0) ? 32'd1 : mag_b;
  assign q_mag      = mag_a / safe_b;
  assign r_mag      = mag_a % safe_b;
  assign quot       = neg_if(div_signed && (a_i[31] ^ b_i[31]), q_mag);
  assign rem        = neg_if(div_signed && a_i[31], r_mag);

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    div0_o   = 1'b0;
    case (op_i)
      MD_MULT: begin
        res_hi_o = prod_s[63:32];
        res_lo_o = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi_o = prod_u[63:32];
        res_lo_o = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi_o = rem;
        res_lo_o = quot;
        div0_o   = (b_i == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div into HI/LO, direct
// mthi/mtlo writes, and a busy flag the hazard unit uses to stall md-class ops.
module mult_div_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   count_q, count_d;
  logic [31:0]           hi_q, hi_d, lo_q, lo_d;
  logic [31:0]           pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic                  pend_div0_q, pend_div0_d;

  logic [31:0]           calc_hi, calc_lo;
  logic                  calc_div0;

  md_calc u_calc (
    .op_i     (md_op),
    .a_i      (md_a),
    .b_i      (md_b),
    .res_hi_o (calc_hi),
    .res_lo_o (calc_lo),
    .div0_o   (calc_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MD_IDLE;
      count_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_div0_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_div0_q <= pend_div0_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_div0_d = pend_div0_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              pend_hi_d   = calc_hi;
              pend_lo_d   = calc_lo;
              pend_div0_d = 1'b0;
              count_d     = MD_CNT_W'(MULT_CYCLES);
              state_d     = MD_RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d   = calc_hi;
              pend_lo_d   = calc_lo;
              pend_div0_d = calc_div0;
              count_d     = MD_CNT_W'(DIV_CYCLES);
              state_d     = MD_RUN;
            end
            MD_MTHI: hi_d = md_a;
            MD_MTLO: lo_d = md_a;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        // Starts arriving here are dropped; the result retires on the 1->0 step.
        count_d = count_q - 1'b1;
        if (count_q == MD_CNT_W'(1)) begin
          state_d = MD_IDLE;
          if (!pend_div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
